// File: rtl/twiddle_cordic_if.sv
// twiddle_cordic_if
//   Request/result handshake bundle between the FFT stage sequencer and the
//   CORDIC twiddle generator.
//   k_i     : twiddle index (requester -> generator)
//   valid_i : k_i is valid
//   ready_o : generator can accept a request
//   twid_o  : [0] = Re{W_N^k}, [1] = Im{W_N^k}, signed Q(FRAC_BITS)
//   valid_o : twid_o holds a result
//   ready_i : consumer takes the result
//   Modports: slave = generator side, master = sequencer side.
interface twiddle_cordic_if #(
  parameter int DATA_WIDTH = 21,
  parameter int N_LOG2     = 4
);
  logic [N_LOG2-1:0]            k_i;
  logic                         valid_i;
  logic                         ready_o;
  logic signed [DATA_WIDTH-1:0] twid_o [0:1];
  logic                         valid_o;
  logic                         ready_i;

  modport slave (
    input  k_i, valid_i, ready_i,
    output ready_o, twid_o, valid_o
  );

  modport master (
    output k_i, valid_i, ready_i,
    input  ready_o, twid_o, valid_o
  );
endinterface

// File: rtl/twiddle_cordic.sv
// twiddle_cordic
//   Iterative CORDIC generator for W_N^k = cos(2*pi*k/N) - j*sin(2*pi*k/N),
//   used in place of a twiddle ROM ahead of the radix-2 butterfly.
//   Ports:
//     clk_i  : clock, rising edge
//     rst_ni : synchronous active-low reset
//     bus    : twiddle_cordic_if.slave (k_i/valid_i/ready_o request,
//              twid_o/valid_o/ready_i result)
//
//   state | meaning
//   IDLE  | ready_o high, waiting for a request
//   ROT   | one micro-rotation per cycle, ITER cycles
//   DONE  | result held on twid_o with valid_o high until ready_i
module twiddle_cordic #(
  parameter int DATA_WIDTH = 21,
  parameter int FRAC_BITS  = 15,
  parameter int N_LOG2     = 4,
  parameter int ITER       = 16
) (
  input logic              clk_i,
  input logic              rst_ni,
  twiddle_cordic_if.slave  bus
);

  localparam int  W  = DATA_WIDTH + 2;
  localparam int  IW = $clog2(ITER);
  localparam real PI = 3.14159265358979323846;

  localparam int ANG_STEP = int'(2.0 * PI * (2.0 ** FRAC_BITS) / (2.0 ** N_LOG2));
  localparam int KINV     = int'(0.6072529 * (2.0 ** FRAC_BITS));

  localparam logic [W-1:0]      ANG_W = W'(ANG_STEP);
  localparam logic [N_LOG2-1:0] RMASK = N_LOG2'((1 << (N_LOG2 - 2)) - 1);

  // atan(2^-n) in Q(FRAC_BITS), evaluated at elaboration. The Taylor series
  // converges quickly for n >= 1; n = 0 is the exact pi/4.
  function automatic int atan_q(input int n);
    real t, p, acc;
    if (n == 0) begin
      acc = PI / 4.0;
    end else begin
      t   = 1.0 / (2.0 ** n);
      p   = t;
      acc = 0.0;
      for (int m = 0; m < 24; m++) begin
        if (m % 2 == 0) acc = acc + p / (2.0 * m + 1.0);
        else            acc = acc - p / (2.0 * m + 1.0);
        p = p * t * t;
      end
    end
    return int'(acc * (2.0 ** FRAC_BITS));
  endfunction

  logic signed [W-1:0] atan_tab [ITER];

  for (genvar g = 0; g < ITER; g++) begin : g_atan
    assign atan_tab[g] = W'(atan_q(g));
  end

  typedef enum logic [1:0] {IDLE, ROT, DONE} state_t;

  state_t              state;
  logic [1:0]          q;
  logic signed [W-1:0] x, y, z;
  logic [IW-1:0]       i;

  logic signed [W-1:0] xs, ys, xn, yn, zn;
  logic signed [W-1:0] re, im;
  logic                unused_hi;

  always_comb begin
    xs = x >>> i;
    ys = y >>> i;
    if (!z[W-1]) begin
      xn = x - ys;
      yn = y + xs;
      zn = z - atan_tab[i];
    end else begin
      xn = x + ys;
      yn = y - xs;
      zn = z + atan_tab[i];
    end
  end

  // Fold the first-quadrant rotation (c, s) of the residual angle into the
  // quadrant selected by the top two index bits; applied to the final
  // rotation result so the fold costs no extra cycle.
  always_comb begin
    re = xn;
    im = -yn;
    case (q)
      2'd0: begin re = xn;  im = -yn; end
      2'd1: begin re = -yn; im = -xn; end
      2'd2: begin re = -xn; im = yn;  end
      2'd3: begin re = yn;  im = xn;  end
      default: ;
    endcase
  end

  assign unused_hi = ^{re[W-1:DATA_WIDTH], im[W-1:DATA_WIDTH], zn[W-1]};

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state          <= IDLE;
      bus.ready_o    <= 1'b1;
      bus.valid_o    <= 1'b0;
      bus.twid_o[0]  <= '0;
      bus.twid_o[1]  <= '0;
      q              <= '0;
      x              <= '0;
      y              <= '0;
      z              <= '0;
      i              <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.valid_i && bus.ready_o) begin
            q           <= bus.k_i[N_LOG2-1 -: 2];
            x           <= W'(KINV);
            y           <= '0;
            z           <= $signed(W'(bus.k_i & RMASK) * ANG_W);
            i           <= '0;
            bus.ready_o <= 1'b0;
            state       <= ROT;
          end
        end
        ROT: begin
          x <= xn;
          y <= yn;
          z <= zn;
          if (i == IW'(ITER - 1)) begin
            i             <= '0;
            bus.twid_o[0] <= re[DATA_WIDTH-1:0];
            bus.twid_o[1] <= im[DATA_WIDTH-1:0];
            bus.valid_o   <= 1'b1;
            state         <= DONE;
          end else begin
            i <= i + 1'b1;
          end
        end
        DONE: begin
          if (bus.ready_i) begin
            bus.valid_o <= 1'b0;
            bus.ready_o <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          bus.ready_o <= 1'b1;
          bus.valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_twiddle_cordic.sv
// tb_twiddle_cordic
//   Directed bench for twiddle_cordic at N = 16, Q15, 21-bit outputs.
//   Inputs are driven and outputs sampled on the falling clock edge.
module tb_twiddle_cordic;

  localparam int DW  = 21;
  localparam int NL  = 4;
  localparam int LAT = 16;
  localparam int TOL = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  twiddle_cordic_if #(.DATA_WIDTH(DW), .N_LOG2(NL)) bus ();

  twiddle_cordic #(
    .DATA_WIDTH(DW), .FRAC_BITS(15), .N_LOG2(NL), .ITER(16)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    int k;
    int re;
    int im;
  } vec_t;

  task automatic check_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_near(input string name, input int act, input int exp);
    checks++;
    if (act > exp + TOL || act < exp - TOL) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d +/-%0d", name, act, exp, TOL);
    end
  endtask

  function automatic int ideal(input int k, input bit imag);
    real th;
    th = 2.0 * 3.14159265358979 * k / 16.0;
    if (imag) return int'(-32768.0 * $sin(th));
    else      return int'(32768.0 * $cos(th));
  endfunction

  // Issues one request and returns once valid_o is seen (or the bound runs
  // out). lat counts falling edges after the accept edge until valid_o.
  task automatic run_one(input int k, output int re, output int im, output int lat);
    int n;
    @(negedge clk);
    bus.k_i     = 4'(k);
    bus.valid_i = 1'b1;
    n = 0;
    while (!bus.ready_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    bus.valid_i = 1'b0;
    lat = 0;
    while (!bus.valid_o && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    re = int'(bus.twid_o[0]);
    im = int'(bus.twid_o[1]);
  endtask

  initial begin
    vec_t vecs [6];
    int re, im, lat, re0, im0;
    int cyc, accepts, nrise, nfall, seen;
    int rise_c [2];
    int fall_c [2];
    int rres [2];
    int ires [2];
    bit drop;

    vecs[0] = '{k: 0,  re: 32768,  im: 0};
    vecs[1] = '{k: 1,  re: 30274,  im: -12540};
    vecs[2] = '{k: 4,  re: 0,      im: -32768};
    vecs[3] = '{k: 8,  re: -32768, im: 0};
    vecs[4] = '{k: 12, re: 0,      im: 32768};
    vecs[5] = '{k: 15, re: 30274,  im: 12540};

    bus.k_i     = '0;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    rst_n       = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset ready_o", int'(bus.ready_o), 1);
    check_eq("reset valid_o", int'(bus.valid_o), 0);
    check_eq("reset twid re", int'(bus.twid_o[0]), 0);
    check_eq("reset twid im", int'(bus.twid_o[1]), 0);
    rst_n = 1'b1;

    // Hand-computed vectors, ready_i held high: one-cycle valid pulse.
    for (int v = 0; v < 6; v++) begin
      run_one(vecs[v].k, re, im, lat);
      check_eq($sformatf("vec k=%0d latency", vecs[v].k), lat, LAT);
      check_near($sformatf("vec k=%0d re", vecs[v].k), re, vecs[v].re);
      check_near($sformatf("vec k=%0d im", vecs[v].k), im, vecs[v].im);
      @(negedge clk);
      check_eq($sformatf("vec k=%0d valid pulse", vecs[v].k), int'(bus.valid_o), 0);
      check_eq($sformatf("vec k=%0d ready back", vecs[v].k), int'(bus.ready_o), 1);
    end

    // Full sweep against a real-valued model.
    for (int k = 0; k < 16; k++) begin
      run_one(k, re, im, lat);
      check_near($sformatf("sweep k=%0d re", k), re, ideal(k, 1'b0));
      check_near($sformatf("sweep k=%0d im", k), im, ideal(k, 1'b1));
      @(negedge clk);
    end

    // Backpressure: result must hold while ready_i is low.
    bus.ready_i = 1'b0;
    run_one(1, re0, im0, lat);
    check_eq("bp latency", lat, LAT);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check_eq("bp valid held", int'(bus.valid_o), 1);
      check_eq("bp ready_o low", int'(bus.ready_o), 0);
      check_eq("bp re stable", int'(bus.twid_o[0]), re0);
      check_eq("bp im stable", int'(bus.twid_o[1]), im0);
    end
    check_near("bp re value", re0, 30274);
    check_near("bp im value", im0, -12540);
    bus.ready_i = 1'b1;
    @(negedge clk);
    check_eq("bp valid drop", int'(bus.valid_o), 0);
    check_eq("bp ready_o rise", int'(bus.ready_o), 1);

    // Back-to-back with valid_i held; k_i changes mid-rotation of the first.
    @(negedge clk);
    bus.k_i     = 4'd2;
    bus.valid_i = 1'b1;
    cyc = 0; accepts = 0; nrise = 0; nfall = 0; seen = 0; drop = 1'b0;
    rise_c = '{0, 0}; fall_c = '{0, 0}; rres = '{0, 0}; ires = '{0, 0};
    while (nfall < 2 && cyc < 100) begin
      if (bus.valid_o && !seen[0]) begin
        if (nrise < 2) begin
          rise_c[nrise] = cyc;
          rres[nrise]   = int'(bus.twid_o[0]);
          ires[nrise]   = int'(bus.twid_o[1]);
        end
        nrise++;
      end
      if (!bus.valid_o && seen[0]) begin
        if (nfall < 2) fall_c[nfall] = cyc;
        nfall++;
      end
      seen = int'(bus.valid_o);
      if (bus.ready_o && bus.valid_i) begin
        accepts++;
        if (accepts == 2) drop = 1'b1;
      end else if (drop) begin
        bus.valid_i = 1'b0;
      end
      if (cyc == 6) bus.k_i = 4'd3;
      @(negedge clk);
      cyc++;
    end
    check_eq("b2b completed", nfall, 2);
    check_eq("b2b first latency", rise_c[0], LAT + 1);
    check_eq("b2b first pulse", fall_c[0] - rise_c[0], 1);
    check_eq("b2b gap", rise_c[1] - fall_c[0], 17);
    check_near("b2b k=2 re", rres[0], 23170);
    check_near("b2b k=2 im", ires[0], -23170);
    check_near("b2b k=3 re", rres[1], 12540);
    check_near("b2b k=3 im", ires[1], -30274);
    bus.valid_i = 1'b0;

    // Reset during rotation aborts the request.
    @(negedge clk);
    bus.k_i     = 4'd5;
    bus.valid_i = 1'b1;
    @(negedge clk);
    bus.valid_i = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("abort ready_o", int'(bus.ready_o), 1);
    check_eq("abort valid_o", int'(bus.valid_o), 0);
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.valid_o) seen++;
    end
    check_eq("abort no result", seen, 0);
    run_one(8, re, im, lat);
    check_eq("after abort latency", lat, LAT);
    check_near("after abort re", re, -32768);
    check_near("after abort im", im, 0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
